// File: rtl/sram_like_axi_bridge_pkg.sv
// Shared constants, FSM encoding and size mapping for the SRAM-like to AXI3 bridge.
package sram_like_axi_bridge_pkg;

  localparam logic [2:0] AXI_SIZE_1B    = 3'b000;
  localparam logic [2:0] AXI_SIZE_2B    = 3'b001;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;

  typedef enum logic [2:0] {
    StIdle,
    StRaddr,
    StRdata,
    StWaddr,
    StWresp
  } bridge_state_e;

  // SRAM size code 3 is not legal on the core side; treat it as a full word.
  function automatic logic [2:0] sram_to_axi_size(input logic [1:0] size);
    logic [2:0] axi_size;
    case (size)
      2'd0:    axi_size = AXI_SIZE_1B;
      2'd1:    axi_size = AXI_SIZE_2B;
      default: axi_size = AXI_SIZE_4B;
    endcase
    return axi_size;
  endfunction

endpackage

// File: rtl/sram_like_axi_bridge_wstrb_gen.sv
// Byte-lane write strobe from SRAM-like size and the low address bits.
module sram_like_axi_bridge_wstrb_gen
  import sram_like_axi_bridge_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] wstrb_o
);

  // Byte selects its lane, halfword selects the aligned half, anything else is a full word.
  always_comb begin
    wstrb_o = 4'b1111;
    case (size_i)
      2'd0:    wstrb_o = 4'b0001 << addr_lo_i;
      2'd1:    wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      default: wstrb_o = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_like_axi_bridge.sv
// Merges the core's inst and data SRAM-like ports onto one single-beat AXI3 master.
// Data has fixed priority; exactly one transaction is outstanding at a time.
module sram_like_axi_bridge
  import sram_like_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        rst,
  // inst port
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  bridge_state_e state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    size_q, size_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [3:0]    id_q, id_d;
  logic          owner_q, owner_d;  // 1: data port owns the transaction
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;

  logic          is_idle;
  logic          grant_data, grant_inst;
  logic          sel_wr;
  logic [1:0]    sel_size;
  logic [31:0]   sel_addr, sel_wdata;
  logic [3:0]    sel_wstrb;
  logic          aw_hs, w_hs;
  logic          resp_ok;

  // Responses carry nothing the bridge needs: one outstanding, owner already known.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

  // Arbitration and the request mux feeding the latch in IDLE.
  always_comb begin
    is_idle    = (state_q == StIdle);
    grant_data = data_req;
    grant_inst = inst_req & ~data_req;
    sel_wr     = grant_data ? data_wr    : inst_wr;
    sel_size   = grant_data ? data_size  : inst_size;
    sel_addr   = grant_data ? data_addr  : inst_addr;
    sel_wdata  = grant_data ? data_wdata : inst_wdata;
  end

  sram_like_axi_bridge_wstrb_gen u_wstrb_gen (
    .size_i    (sel_size),
    .addr_lo_i (sel_addr[1:0]),
    .wstrb_o   (sel_wstrb)
  );

  // Handshake strobes and the response completion the owner sees.
  always_comb begin
    aw_hs   = awvalid_q & awready;
    w_hs    = wvalid_q & wready;
    resp_ok = ((state_q == StRdata) & rvalid) | ((state_q == StWresp) & bvalid);
  end

  // Next-state logic for the transaction FSM and its registered AXI valids/readies.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    wstrb_d   = wstrb_q;
    id_d      = id_q;
    owner_d   = owner_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      StIdle: begin
        if (grant_data | grant_inst) begin
          owner_d = grant_data;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          size_d  = sram_to_axi_size(sel_size);
          wstrb_d = sel_wstrb;
          id_d    = grant_data ? DATA_ID : INST_ID;
          if (sel_wr) begin
            state_d   = StWaddr;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = StRaddr;
            arvalid_d = 1'b1;
          end
        end
      end
      StRaddr: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdata;
        end
      end
      StRdata: begin
        if (rvalid) begin
          rready_d = 1'b0;
          state_d  = StIdle;
        end
      end
      StWaddr: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = StWresp;
        end
      end
      StWresp: begin
        if (bvalid) begin
          bready_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched request; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      id_q      <= '0;
      owner_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      wstrb_q   <= wstrb_d;
      id_q      <= id_d;
      owner_q   <= owner_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign inst_addr_ok = is_idle & grant_inst;
  assign data_addr_ok = is_idle & grant_data;
  assign inst_data_ok = resp_ok & ~owner_q;
  assign data_data_ok = resp_ok & owner_q;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arid    = id_q;
  assign araddr  = addr_q;
  assign arlen   = 4'd0;
  assign arsize  = size_q;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = id_q;
  assign awaddr  = addr_q;
  assign awlen   = 4'd0;
  assign awsize  = size_q;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = awvalid_q;

  assign wid    = id_q;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign wlast  = 1'b1;
  assign wvalid = wvalid_q;
  assign bready = bready_q;

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Self-checking bench: scenario tasks plus randomized transactions against a behavioural model.
module tb_sram_like_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int errors = 0;
  int checks = 0;

  // Observations recorded by the slave/driver task.
  int          o_acc_cyc, o_dok_cyc, o_extra_aok, o_other_aok, o_bad_dok;
  int          o_ar_hs, o_aw_hs, o_w_hs, o_rr_cyc, o_awv_cyc, o_wv_cyc;
  bit          o_timeout;
  logic [31:0] o_araddr, o_awaddr, o_wdata, o_rdata;
  logic [2:0]  o_arsize, o_awsize;
  logic [3:0]  o_arid, o_awid, o_wid, o_wstrb;
  logic        o_wlast;

  sram_like_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // Model: expected AXI size code.
  function automatic logic [2:0] exp_size(input logic [1:0] size);
    return (size == 2'd3) ? 3'd2 : {1'b0, size};
  endfunction

  // Model: lanes covered by an access of 2^size bytes at its naturally aligned base.
  function automatic logic [3:0] exp_strb(input logic [1:0] size, input logic [31:0] addr);
    int nb, base;
    logic [3:0] s;
    nb   = 1 << exp_size(size);
    base = int'(addr[1:0]) & ~(nb - 1);
    for (int lane = 0; lane < 4; lane++) s[lane] = (lane >= base) && (lane < base + nb);
    return s;
  endfunction

  // Drives one request on a port and plays a slave with per-channel wait states.
  task automatic run_txn(input bit port, input bit wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdv,
                         input int ar_w, input int r_w, input int aw_w, input int w_w,
                         input int b_w, input bit hold);
    int cyc, arc, rc, awc, wc, bc;
    bit done, acc, own_aok, oth_aok, own_dok, oth_dok;
    o_acc_cyc = -1; o_dok_cyc = -1; o_extra_aok = 0; o_other_aok = 0; o_bad_dok = 0;
    o_ar_hs = 0; o_aw_hs = 0; o_w_hs = 0; o_rr_cyc = 0; o_awv_cyc = 0; o_wv_cyc = 0;
    o_timeout = 0; o_rdata = 'x;
    if (port) begin
      data_req = 1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
    end else begin
      inst_req = 1; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wd;
    end
    rdata = rdv;
    cyc = 0; done = 0; acc = 0; arc = 0; rc = 0; awc = 0; wc = 0; bc = 0;
    while (!done && cyc < 300) begin
      arready = arvalid && (arc >= ar_w); if (arvalid) arc++;
      rvalid  = rready  && (rc  >= r_w);  if (rready)  rc++;
      awready = awvalid && (awc >= aw_w); if (awvalid) awc++;
      wready  = wvalid  && (wc  >= w_w);  if (wvalid)  wc++;
      bvalid  = bready  && (bc  >= b_w);  if (bready)  bc++;
      @(negedge clk);
      own_aok = port ? data_addr_ok : inst_addr_ok;
      oth_aok = port ? inst_addr_ok : data_addr_ok;
      own_dok = port ? data_data_ok : inst_data_ok;
      oth_dok = port ? inst_data_ok : data_data_ok;
      if (own_aok) begin
        if (!acc) begin acc = 1; o_acc_cyc = cyc; end
        else o_extra_aok++;
      end
      if (oth_aok) o_other_aok++;
      if (oth_dok || (own_aok && own_dok)) o_bad_dok++;
      if (arvalid && arready) begin
        o_ar_hs++; o_araddr = araddr; o_arsize = arsize; o_arid = arid;
      end
      if (awvalid && awready) begin
        o_aw_hs++; o_awaddr = awaddr; o_awsize = awsize; o_awid = awid;
      end
      if (wvalid && wready) begin
        o_w_hs++; o_wdata = wdata; o_wstrb = wstrb; o_wlast = wlast; o_wid = wid;
      end
      if (rready)  o_rr_cyc++;
      if (awvalid) o_awv_cyc++;
      if (wvalid)  o_wv_cyc++;
      if (own_dok) begin
        done = 1; o_dok_cyc = cyc; o_rdata = port ? data_rdata : inst_rdata;
      end
      @(posedge clk); #1;
      if (acc && !hold) begin
        if (port) data_req = 0; else inst_req = 0;
      end
      cyc++;
    end
    if (!done) o_timeout = 1;
    if (port) data_req = 0; else inst_req = 0;
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    #12;
    checks++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin errors++;
      $display("FAIL reset_valids got=%b exp=00000", {arvalid, rready, awvalid, wvalid, bready}); end
    checks++; if ({araddr, arid, wstrb, wdata} !== 72'd0) begin errors++;
      $display("FAIL reset_regs got=%h exp=0", {araddr, arid, wstrb, wdata}); end
    checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin
      errors++; $display("FAIL reset_oks got=%b exp=0000",
                         {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    checks++; if ({arlen, arburst, awburst, arlock, arcache, arprot} !== {4'd0, 2'b01, 2'b01,
      2'd0, 4'd0, 3'd0}) begin errors++; $display("FAIL reset_consts got=%h",
      {arlen, arburst, awburst, arlock, arcache, arprot}); end
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic test_inst_read;
    run_txn(0, 0, 2'd2, 32'hBFC0_0000, 32'h0, 32'h3C08_0001, 0, 0, 0, 0, 0, 0);
    checks++; if (o_acc_cyc !== 0) begin errors++;
      $display("FAIL t1_accept got=%0d exp=0", o_acc_cyc); end
    checks++; if ({o_arid, o_araddr, o_arsize} !== {4'd0, 32'hBFC0_0000, 3'd2}) begin errors++;
      $display("FAIL t1_ar got=%h exp=%h", {o_arid, o_araddr, o_arsize},
               {4'd0, 32'hBFC0_0000, 3'd2}); end
    checks++; if (o_dok_cyc !== 2) begin errors++;
      $display("FAIL t1_latency got=%0d exp=2", o_dok_cyc); end
    checks++; if (o_rdata !== 32'h3C08_0001) begin errors++;
      $display("FAIL t1_rdata got=%h exp=3c080001", o_rdata); end
  endtask

  task automatic test_arbitration;
    inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC0_0004;
    run_txn(1, 0, 2'd2, 32'h8000_1000, 32'h0, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    checks++; if (o_acc_cyc !== 0 || o_other_aok !== 0) begin errors++;
      $display("FAIL t2_grant got=acc%0d/inst_aok%0d exp=0/0", o_acc_cyc, o_other_aok); end
    checks++; if (o_arid !== 4'd1) begin errors++;
      $display("FAIL t2_arid got=%0d exp=1", o_arid); end
    checks++; if (o_rdata !== 32'h1234_5678 || o_bad_dok !== 0) begin errors++;
      $display("FAIL t2_data got=%h/%0d exp=12345678/0", o_rdata, o_bad_dok); end
    run_txn(0, 0, 2'd2, 32'hBFC0_0004, 32'h0, 32'h0000_0000, 0, 0, 0, 0, 0, 0);
    checks++; if (o_acc_cyc !== 0 || o_arid !== 4'd0 || o_araddr !== 32'hBFC0_0004) begin
      errors++; $display("FAIL t2_inst_after got=acc%0d id%0d %h exp=0 0 bfc00004",
                         o_acc_cyc, o_arid, o_araddr); end
  endtask

  task automatic test_write_byte;
    run_txn(1, 1, 2'd0, 32'h8000_0003, 32'hAA00_0000, 32'h0, 0, 0, 0, 2, 1, 0);
    checks++; if ({o_awsize, o_wstrb, o_wlast} !== {3'd0, 4'b1000, 1'b1}) begin errors++;
      $display("FAIL t3_aw_w got=%h exp=%h", {o_awsize, o_wstrb, o_wlast},
               {3'd0, 4'b1000, 1'b1}); end
    checks++; if ({o_awaddr, o_wdata} !== {32'h8000_0003, 32'hAA00_0000}) begin errors++;
      $display("FAIL t3_addr_data got=%h", {o_awaddr, o_wdata}); end
    checks++; if (o_aw_hs !== 1 || o_awv_cyc !== 1 || o_wv_cyc !== 3 || o_w_hs !== 1) begin
      errors++; $display("FAIL t3_valids got=awhs%0d awv%0d wv%0d whs%0d exp=1 1 3 1",
                         o_aw_hs, o_awv_cyc, o_wv_cyc, o_w_hs); end
    checks++; if (o_dok_cyc !== 5) begin errors++;
      $display("FAIL t3_latency got=%0d exp=5", o_dok_cyc); end
  endtask

  task automatic test_write_sizes;
    run_txn(1, 1, 2'd1, 32'h8000_0002, 32'hBEEF_0000, 32'h0, 0, 0, 0, 0, 0, 0);
    checks++; if ({o_awsize, o_wstrb} !== {3'd1, 4'b1100}) begin errors++;
      $display("FAIL t4_sh got=%h exp=%h", {o_awsize, o_wstrb}, {3'd1, 4'b1100}); end
    checks++; if (o_dok_cyc !== 2) begin errors++;
      $display("FAIL t4_sh_latency got=%0d exp=2", o_dok_cyc); end
    run_txn(1, 1, 2'd3, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 0, 0, 0, 0, 0, 0);
    checks++; if ({o_awsize, o_wstrb, o_awid} !== {3'd2, 4'b1111, 4'd1}) begin errors++;
      $display("FAIL t4_sw got=%h exp=%h", {o_awsize, o_wstrb, o_awid},
               {3'd2, 4'b1111, 4'd1}); end
  endtask

  task automatic test_stall;
    run_txn(0, 0, 2'd2, 32'hBFC0_0100, 32'h0, 32'h0BAD_F00D, 0, 10, 0, 0, 0, 1);
    inst_req = 0;
    checks++; if (o_extra_aok !== 0) begin errors++;
      $display("FAIL t5_extra_aok got=%0d exp=0", o_extra_aok); end
    checks++; if (o_rr_cyc !== 11 || o_dok_cyc !== 12) begin errors++;
      $display("FAIL t5_rready got=rr%0d dok%0d exp=11 12", o_rr_cyc, o_dok_cyc); end
    checks++; if (o_rdata !== 32'h0BAD_F00D || o_timeout !== 0) begin errors++;
      $display("FAIL t5_rdata got=%h/%0d exp=0badf00d/0", o_rdata, o_timeout); end
  endtask

  task automatic test_reset_mid;
    inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC0_0200;
    @(posedge clk); #1; inst_req = 0;
    arready = 1;
    @(posedge clk); #1; arready = 0;
    checks++; if (rready !== 1'b1) begin errors++;
      $display("FAIL t6_in_rdata got=%b exp=1", rready); end
    #2 rst = 1; #1;
    checks++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin errors++;
      $display("FAIL t6_reset_valids got=%b exp=00000",
               {arvalid, rready, awvalid, wvalid, bready}); end
    @(posedge clk); #1; rst = 0;
    run_txn(1, 1, 2'd2, 32'h8000_0020, 32'h5555_AAAA, 32'h0, 0, 0, 0, 0, 0, 0);
    checks++; if (o_acc_cyc !== 0 || o_dok_cyc !== 2 || o_wdata !== 32'h5555_AAAA) begin
      errors++; $display("FAIL t6_after got=acc%0d dok%0d %h exp=0 2 5555aaaa",
                         o_acc_cyc, o_dok_cyc, o_wdata); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      bit          port, wr;
      logic [1:0]  size;
      logic [31:0] addr, wd, rdv;
      int          aw, r, aww, ww, bw, exp_lat;
      port = 1'($urandom); wr = 1'($urandom); size = 2'($urandom);
      addr = $urandom; wd = $urandom; rdv = $urandom;
      aw = $urandom_range(0, 3); r = $urandom_range(0, 3); aww = $urandom_range(0, 3);
      ww = $urandom_range(0, 3); bw = $urandom_range(0, 3);
      run_txn(port, wr, size, addr, wd, rdv, aw, r, aww, ww, bw, 0);
      exp_lat = wr ? 2 + ((aww > ww) ? aww : ww) + bw : 2 + aw + r;
      checks++; if (o_acc_cyc !== 0 || o_dok_cyc !== exp_lat || o_bad_dok !== 0) begin
        errors++; $display("FAIL rnd%0d_timing got=acc%0d dok%0d bad%0d exp=0 %0d 0",
                           n, o_acc_cyc, o_dok_cyc, o_bad_dok, exp_lat); end
      if (wr) begin
        checks++; if ({o_awaddr, o_awsize, o_awid, o_wstrb, o_wdata, o_wid} !==
                      {addr, exp_size(size), port ? 4'd1 : 4'd0, exp_strb(size, addr), wd,
                       port ? 4'd1 : 4'd0}) begin
          errors++; $display("FAIL rnd%0d_write got=%h %0d %0d %b %h exp=%h %0d %0d %b %h", n,
                             o_awaddr, o_awsize, o_awid, o_wstrb, o_wdata, addr,
                             exp_size(size), port, exp_strb(size, addr), wd); end
      end else begin
        checks++; if ({o_araddr, o_arsize, o_arid, o_rdata} !==
                      {addr, exp_size(size), port ? 4'd1 : 4'd0, rdv}) begin
          errors++; $display("FAIL rnd%0d_read got=%h %0d %0d %h exp=%h %0d %0d %h", n,
                             o_araddr, o_arsize, o_arid, o_rdata, addr, exp_size(size),
                             port, rdv); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_inst_read;
    test_arbitration;
    test_write_byte;
    test_write_sizes;
    test_stall;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
